shift_add_mult_ctrl: RTL and testbench

SHIFT_ADD_MULT_CTRL -- requirements
Module: shift_add_mult_ctrl

---
 rtl/shift_add_mult_ctrl.sv | 109 ++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for a shift-and-add multiplier. The datapath (accumulator and
// multiplier shift register) lives outside this block; this FSM only issues
// the load / add / shift strobes and tracks how many multiplier bits remain.
// All outputs are Moore outputs decoded from the state and bit counter.
module shift_add_mult_ctrl #(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     q0,
  input  logic                     ack,
  output logic                     load,
  output logic                     add_en,
  output logic                     shift_en,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(N+1)-1:0]   bits_left
);

  localparam int W = $clog2(N + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_TEST  = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]   state_reg;
  logic [2:0]   state_next;
  logic [W-1:0] bits_reg;
  logic [W-1:0] bits_next;

  // Next-state and counter logic; abort out of any active state wins over
  // every other transition, and leaving for IDLE always clears the counter.
  always_comb begin
    state_next = state_reg;
    bits_next  = bits_reg;
    if (abort && (state_reg != S_IDLE)) begin
      state_next = S_IDLE;
      bits_next  = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          bits_next = '0;
          if (start) begin
            state_next = S_LOAD;
          end
        end
        S_LOAD: begin
          bits_next  = W'(N);
          state_next = S_TEST;
        end
        S_TEST: begin
          state_next = q0 ? S_ADD : S_SHIFT;
        end
        S_ADD: begin
          state_next = S_SHIFT;
        end
        S_SHIFT: begin
          if (bits_reg == W'(1)) begin
            bits_next  = '0;
            state_next = S_DONE;
          end else if (bits_reg == '0) begin
            // Unreachable in normal operation; never wrap the counter.
            bits_next  = '0;
            state_next = S_IDLE;
          end else begin
            bits_next  = bits_reg - W'(1);
            state_next = S_TEST;
          end
        end
        S_DONE: begin
          // start alongside ack is deliberately not remembered.
          if (ack) begin
            bits_next  = '0;
            state_next = S_IDLE;
          end
        end
        default: begin
          bits_next  = '0;
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      bits_reg  <= '0;
    end else begin
      state_reg <= state_next;
      bits_reg  <= bits_next;
    end
  end

  // Moore output decode: exactly one strobe per datapath state.
  assign load      = (state_reg == S_LOAD);
  assign add_en    = (state_reg == S_ADD);
  assign shift_en  = (state_reg == S_SHIFT);
  assign done      = (state_reg == S_DONE);
  assign busy      = (state_reg != S_IDLE);
  assign bits_left = bits_reg;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed testbench for shift_add_mult_ctrl (N=8) with a small shift-add
// datapath model driving q0 for the product test. Cycle numbering: the
// cycle with load=1 is cycle 1; done first appears 1+2N+k cycles later.
module tb_shift_add_mult_ctrl;

  localparam int N = 8;
  localparam int W = $clog2(N + 1);

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic         q0;
  logic         ack;
  logic         load;
  logic         add_en;
  logic         shift_en;
  logic         busy;
  logic         done;
  logic [W-1:0] bits_left;

  logic         q0_force;
  logic         use_dp;
  logic [N:0]   dp_a;
  logic [N-1:0] dp_q;
  logic [N-1:0] dp_m;
  logic [N-1:0] dp_mplier;

  int checks = 0;
  int errors = 0;

  shift_add_mult_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .q0        (q0),
    .ack       (ack),
    .load      (load),
    .add_en    (add_en),
    .shift_en  (shift_en),
    .busy      (busy),
    .done      (done),
    .bits_left (bits_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign q0 = use_dp ? dp_q[0] : q0_force;

  // Reference shift-add datapath obeying the controller strobes.
  always_ff @(posedge clk) begin
    if (load) begin
      dp_a <= '0;
      dp_q <= dp_mplier;
    end else if (add_en) begin
      dp_a <= dp_a + {1'b0, dp_m};
    end else if (shift_en) begin
      dp_q <= {dp_a[0], dp_q[N-1:1]};
      dp_a <= {1'b0, dp_a[N:1]};
    end
  end

  // Runs from the load cycle to the first done cycle, counting strobes and
  // protocol violations; lat = -1 if done never arrives.
  task automatic wait_done(input int pulse_at, input bit ack_busy,
                           output int lat, output int n_add,
                           output int n_shift, output int n_odd,
                           output int bad);
    int exp_bits;
    bit prev_add;
    lat = -1; n_add = 0; n_shift = 0; n_odd = 0; bad = 0;
    exp_bits = N; prev_add = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      start = (c == pulse_at);
      ack   = ack_busy;
      @(posedge clk); #1;
      if ((int'(load) + int'(add_en) + int'(shift_en) + int'(done)) > 1) bad++;
      if (load !== 1'b0) bad++;
      if (busy !== 1'b1) bad++;
      if (prev_add && (shift_en !== 1'b1)) bad++;
      if (bits_left !== W'(exp_bits)) bad++;
      if (add_en === 1'b1) n_add++;
      if (shift_en === 1'b1) begin
        n_shift++;
        if ((c % 2) == 1) n_odd++;
        exp_bits--;
      end
      prev_add = (add_en === 1'b1);
      if (done === 1'b1) begin
        lat = c;
        start = 1'b0;
        ack = 1'b0;
        break;
      end
    end
    start = 1'b0;
    ack = 1'b0;
  endtask

  task automatic begin_op(input string name);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (load !== 1'b1) begin
      errors++;
      $display("FAIL %s_load: load=%b required 1", name, load);
    end
  endtask

  task automatic finish_op(input string name);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_ack: busy=%b done=%b required 0 0", name, busy, done);
    end
  endtask

  task automatic abort_op();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({load, add_en, shift_en, busy, done} !== 5'b0 || bits_left !== '0) begin
      errors++;
      $display("FAIL reset_state: outs=%b bits_left=%0d required 00000 0",
               {load, add_en, shift_en, busy, done}, bits_left);
    end
    rst_n = 1'b1;
    begin_op("reset_release_start");
    abort_op();
    $display("test_reset done");
  endtask

  task automatic test_zeros();
    int lat, na, ns, no, bad;
    q0_force = 1'b0;
    begin_op("zeros");
    wait_done(0, 1'b0, lat, na, ns, no, bad);
    checks++;
    if (lat !== 2 * N + 1) begin
      errors++;
      $display("FAIL zeros_latency: got %0d required %0d", lat, 2 * N + 1);
    end
    checks++;
    if (na !== 0 || ns !== N || no !== 0 || bad !== 0) begin
      errors++;
      $display("FAIL zeros_strobes: add=%0d shift=%0d odd=%0d bad=%0d required 0 %0d 0 0",
               na, ns, no, bad, N);
    end
    finish_op("zeros");
    $display("test_zeros done: latency %0d", lat);
  endtask

  task automatic test_ones();
    int lat, na, ns, no, bad;
    q0_force = 1'b1;
    begin_op("ones");
    // ack held high while busy must be ignored.
    wait_done(0, 1'b1, lat, na, ns, no, bad);
    checks++;
    if (lat !== 3 * N + 1) begin
      errors++;
      $display("FAIL ones_latency: got %0d required %0d", lat, 3 * N + 1);
    end
    checks++;
    if (na !== N || ns !== N || bad !== 0) begin
      errors++;
      $display("FAIL ones_strobes: add=%0d shift=%0d bad=%0d required %0d %0d 0",
               na, ns, bad, N, N);
    end
    finish_op("ones");
    $display("test_ones done: latency %0d", lat);
  endtask

  task automatic test_product();
    int lat, na, ns, no, bad;
    logic [2*N-1:0] prod;
    dp_m = 8'hA5;
    dp_mplier = 8'h3C;
    use_dp = 1'b1;
    begin_op("product");
    wait_done(4, 1'b0, lat, na, ns, no, bad);
    prod = {dp_a[N-1:0], dp_q};
    checks++;
    if (lat !== 21) begin
      errors++;
      $display("FAIL product_latency: got %0d required 21", lat);
    end
    checks++;
    if (prod !== 16'h26AC) begin
      errors++;
      $display("FAIL product_value: got 0x%04h required 0x26AC", prod);
    end
    checks++;
    if (na !== 4 || ns !== N || bad !== 0) begin
      errors++;
      $display("FAIL product_strobes: add=%0d shift=%0d bad=%0d required 4 %0d 0",
               na, ns, bad, N);
    end
    finish_op("product");
    use_dp = 1'b0;
    $display("test_product done: product 0x%04h latency %0d", prod, lat);
  endtask

  task automatic test_abort();
    int lat, na, ns, no, bad;
    q0_force = 1'b1;
    begin_op("abort");
    repeat (3) @(posedge clk);
    #1;
    abort_op();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bits_left !== '0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b done=%b bits_left=%0d required 0 0 0",
               busy, done, bits_left);
    end
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d active cycles after abort required 0", bad);
    end
    // abort is ignored in IDLE, so start alongside it still launches.
    q0_force = 1'b0;
    abort = 1'b1;
    begin_op("abort_idle_start");
    abort = 1'b0;
    wait_done(0, 1'b0, lat, na, ns, no, bad);
    checks++;
    if (lat !== 2 * N + 1 || bad !== 0) begin
      errors++;
      $display("FAIL abort_rerun: latency %0d bad %0d required %0d 0", lat, bad, 2 * N + 1);
    end
    finish_op("abort_rerun");
    $display("test_abort done");
  endtask

  task automatic test_done_hold();
    int lat, na, ns, no, bad;
    q0_force = 1'b0;
    begin_op("hold");
    wait_done(0, 1'b0, lat, na, ns, no, bad);
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done !== 1'b1 || busy !== 1'b1 || load !== 1'b0 || add_en !== 1'b0 ||
          shift_en !== 1'b0 || bits_left !== '0) bad++;
    end
    checks++;
    if (lat !== 2 * N + 1 || bad !== 0) begin
      errors++;
      $display("FAIL hold_done: latency %0d bad %0d required %0d 0", lat, bad, 2 * N + 1);
    end
    ack = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || load !== 1'b0) begin
      errors++;
      $display("FAIL hold_ack_start: busy=%b done=%b load=%b required 0 0 0",
               busy, done, load);
    end
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (load !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_no_queue: %0d cycles with activity required 0", bad);
    end
    begin_op("hold_restart");
    abort_op();
    $display("test_done_hold done");
  endtask

  task automatic test_reset_mid_add();
    q0_force = 1'b1;
    begin_op("midadd");
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (add_en !== 1'b1) begin
      errors++;
      $display("FAIL midadd_in_add: add_en=%b required 1", add_en);
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({load, add_en, shift_en, busy, done} !== 5'b0 || bits_left !== '0) begin
      errors++;
      $display("FAIL midadd_reset: outs=%b bits_left=%0d required 00000 0",
               {load, add_en, shift_en, busy, done}, bits_left);
    end
    rst_n = 1'b1;
    begin_op("midadd_restart");
    abort_op();
    $display("test_reset_mid_add done");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    ack = 1'b0;
    q0_force = 1'b0;
    use_dp = 1'b0;
    dp_m = '0;
    dp_mplier = '0;
    test_reset();
    test_zeros();
    test_ones();
    test_product();
    test_abort();
    test_done_hold();
    test_reset_mid_add();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
